// File: rtl/common_pkg.sv
// Shared execute-stage types: operand selects, ALU functions, flag bundle and FSM states.
package common;

  localparam int EX_MUL_LAT = 4;

  typedef logic [4:0] regid_t;

  typedef enum logic { MUX_A_REGFILE, MUX_A_PC  } mux_a_t;
  typedef enum logic { MUX_B_REGFILE, MUX_B_IMM } mux_b_t;

  typedef enum logic [2:0] {
    FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_SLT, FUNC_SLL, FUNC_SRL
  } func_t;

  typedef enum logic { TLBW_OFF, TLBW_ON } tlbwrite_t;

  typedef struct packed {
    logic      mem;
    logic      store;
    logic      isbyte;
    logic      mul;
    logic      regw;
    logic      jump;
    logic      branch;
    logic      iret;
    tlbwrite_t tlbwrite;
  } ex_flags_t;

  typedef enum logic { EX_IDLE, EX_MUL } ex_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU used by the execute stage.
module alu import common::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  func_t           func,
  output logic [XLEN-1:0] y
);

  localparam int SW = $clog2(XLEN);

  always_comb begin
    y = '0;
    case (func)
      FUNC_ADD: y = a + b;
      FUNC_SUB: y = a - b;
      FUNC_AND: y = a & b;
      FUNC_OR:  y = a | b;
      FUNC_XOR: y = a ^ b;
      FUNC_SLT: y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      FUNC_SLL: y = a << b[SW-1:0];
      FUNC_SRL: y = a >> b[SW-1:0];
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/mul_pipe.sv
// Registered multiplier: operands captured on start, product valid MUL_LAT-1 edges later
// and held until the next start; MUL_LAT==1 degenerates to a combinational product.
module mul_pipe #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] p
);

  generate
    if (MUL_LAT == 1) begin : g_comb
      assign p = a * b;
    end else begin : g_pipe
      logic [XLEN-1:0] stg [MUL_LAT-1];

      // Stage 0 only loads on start, so the tail settles on the product and stays there.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < MUL_LAT-1; i++) stg[i] <= '0;
        end else begin
          if (start) stg[0] <= a * b;
          for (int i = 1; i < MUL_LAT-1; i++) stg[i] <= stg[i-1];
        end
      end

      assign p = stg[MUL_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/stage_ex_mc.sv
// Multi-cycle execute stage: 1-cycle ALU ops, MUL_LAT-cycle multiply with input stall,
// valid/ready hold on the output, synchronous flush.
module stage_ex_mc import common::*; #(
  parameter  int XLEN     = 32,
  parameter  int MUL_LAT  = EX_MUL_LAT,
  parameter  int NTHREADS = 4,
  localparam int TW       = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [TW-1:0]   id_thread,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_r1,
  input  logic [XLEN-1:0] id_r2,
  input  logic [XLEN-1:0] id_imm,
  input  mux_a_t          id_a,
  input  mux_b_t          id_b,
  input  func_t           id_alu_func,
  input  regid_t          id_dst,
  input  ex_flags_t       id_flags,
  output logic            tl_valid,
  input  logic            tl_ready,
  output logic [TW-1:0]   tl_thread,
  output logic [XLEN-1:0] tl_pc,
  output regid_t          tl_dst,
  output logic [XLEN-1:0] tl_r2,
  output ex_flags_t       tl_flags,
  output logic [XLEN-1:0] tl_data,
  output logic            tl_isequal
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  ex_state_t       state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] op_a, op_b, alu_y, prod;
  logic            fire_in, fire_out, out_free;
  ex_flags_t       flags_in;

  logic [TW-1:0]   sb_thread;
  logic [XLEN-1:0] sb_pc, sb_r2;
  regid_t          sb_dst;
  ex_flags_t       sb_flags;
  logic            sb_isequal;

  assign op_a     = (id_a == MUX_A_REGFILE) ? id_r1 : id_pc;
  assign op_b     = (id_b == MUX_B_REGFILE) ? id_r2 : id_imm;
  assign out_free = !tl_valid || tl_ready;
  assign id_ready = !flush && (state == EX_IDLE) && out_free;
  assign fire_in  = id_valid && id_ready;
  assign fire_out = tl_valid && tl_ready;

  // TLB writes are resolved further down the pipe, never here.
  always_comb begin
    flags_in          = id_flags;
    flags_in.tlbwrite = TLBW_OFF;
  end

  alu #(.XLEN(XLEN)) u_alu (.a(op_a), .b(op_b), .func(id_alu_func), .y(alu_y));

  mul_pipe #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) u_mul (
    .clk(clk), .rst(rst), .start(fire_in && id_flags.mul),
    .a(id_r1), .b(id_r2), .p(prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EX_IDLE;
      cnt        <= '0;
      tl_valid   <= 1'b0;
      tl_thread  <= '0;
      tl_pc      <= '0;
      tl_dst     <= '0;
      tl_r2      <= '0;
      tl_flags   <= '0;
      tl_data    <= '0;
      tl_isequal <= 1'b0;
      sb_thread  <= '0;
      sb_pc      <= '0;
      sb_dst     <= '0;
      sb_r2      <= '0;
      sb_flags   <= '0;
      sb_isequal <= 1'b0;
    end else if (flush) begin
      tl_valid <= 1'b0;
      state    <= EX_IDLE;
      cnt      <= '0;
    end else begin
      if (fire_out) tl_valid <= 1'b0;
      case (state)
        EX_IDLE: begin
          if (fire_in) begin
            if (id_flags.mul && MUL_LAT > 1) begin
              state      <= EX_MUL;
              cnt        <= CW'(MUL_LAT-1);
              sb_thread  <= id_thread;
              sb_pc      <= id_pc;
              sb_dst     <= id_dst;
              sb_r2      <= id_r2;
              sb_flags   <= flags_in;
              sb_isequal <= (id_r1 == id_r2);
            end else begin
              tl_valid   <= 1'b1;
              tl_thread  <= id_thread;
              tl_pc      <= id_pc;
              tl_dst     <= id_dst;
              tl_r2      <= id_r2;
              tl_flags   <= flags_in;
              tl_data    <= id_flags.mul ? prod : alu_y;
              tl_isequal <= (id_r1 == id_r2);
            end
          end
        end
        EX_MUL: begin
          // Parked at cnt==1 until the output register can take the product.
          if (cnt != CW'(1)) begin
            cnt <= cnt - 1'b1;
          end else if (out_free) begin
            tl_valid   <= 1'b1;
            tl_thread  <= sb_thread;
            tl_pc      <= sb_pc;
            tl_dst     <= sb_dst;
            tl_r2      <= sb_r2;
            tl_flags   <= sb_flags;
            tl_data    <= prod;
            tl_isequal <= sb_isequal;
            state      <= EX_IDLE;
            cnt        <= '0;
          end
        end
        default: state <= EX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_ex_mc.sv
// Directed bench for stage_ex_mc: ALU, multiply stall, hold, flush, branch compare, reset.
module tb_stage_ex_mc;
  import common::*;

  localparam int XLEN = 32;
  localparam int TW   = 2;

  logic            clk = 1'b0;
  logic            rst, flush, id_valid, id_ready, tl_valid, tl_ready, tl_isequal;
  logic [TW-1:0]   id_thread, tl_thread;
  logic [XLEN-1:0] id_pc, id_r1, id_r2, id_imm, tl_pc, tl_r2, tl_data;
  mux_a_t          id_a;
  mux_b_t          id_b;
  func_t           id_alu_func;
  regid_t          id_dst, tl_dst;
  ex_flags_t       id_flags, tl_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_ex_mc #(.XLEN(XLEN), .MUL_LAT(4), .NTHREADS(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_thread(id_thread), .id_pc(id_pc),
    .id_r1(id_r1), .id_r2(id_r2), .id_imm(id_imm), .id_a(id_a), .id_b(id_b),
    .id_alu_func(id_alu_func), .id_dst(id_dst), .id_flags(id_flags),
    .tl_valid(tl_valid), .tl_ready(tl_ready), .tl_thread(tl_thread), .tl_pc(tl_pc),
    .tl_dst(tl_dst), .tl_r2(tl_r2), .tl_flags(tl_flags), .tl_data(tl_data),
    .tl_isequal(tl_isequal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Present one instruction on the IDEX side (valid asserted).
  task automatic drive(input logic [XLEN-1:0] pc, r1, r2, imm, input mux_a_t a, input mux_b_t b,
                       input func_t f, input logic mul, input logic [TW-1:0] thr,
                       input regid_t dst);
    id_valid          = 1'b1;
    id_pc             = pc;
    id_r1             = r1;
    id_r2             = r2;
    id_imm            = imm;
    id_a              = a;
    id_b              = b;
    id_alu_func       = f;
    id_thread         = thr;
    id_dst            = dst;
    id_flags          = '0;
    id_flags.regw     = 1'b1;
    id_flags.mul      = mul;
    id_flags.tlbwrite = TLBW_ON;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; tl_ready = 1'b1; id_valid = 1'b0;
    id_pc = '0; id_r1 = '0; id_r2 = '0; id_imm = '0; id_a = MUX_A_REGFILE;
    id_b = MUX_B_REGFILE; id_alu_func = FUNC_ADD; id_thread = '0; id_dst = '0; id_flags = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_valid", tl_valid, 0);
    chk("rst_data", tl_data, 0);
    chk("rst_flags", tl_flags, 0);
    chk("rst_ready", id_ready, 1);

    // ADD 5 + imm 7
    drive(32'h40, 5, 3, 7, MUX_A_REGFILE, MUX_B_IMM, FUNC_ADD, 1'b0, 2'd1, 5'd3);
    chk("add_ready", id_ready, 1);
    cyc();
    chk("add_valid", tl_valid, 1);
    chk("add_data", tl_data, 12);
    chk("add_iseq", tl_isequal, 0);
    chk("add_tlbw", tl_flags.tlbwrite, TLBW_OFF);
    chk("add_pc", tl_pc, 32'h40);
    chk("add_dst", tl_dst, 3);
    id_valid = 1'b0;
    cyc();
    chk("drain_valid", tl_valid, 0);

    // MUL 6*7 then an ADD waiting behind it
    drive(32'h80, 6, 7, 0, MUX_A_REGFILE, MUX_B_REGFILE, FUNC_ADD, 1'b1, 2'd2, 5'd9);
    chk("mul_ready0", id_ready, 1);
    cyc();
    drive(32'h84, 1, 9, 2, MUX_A_REGFILE, MUX_B_IMM, FUNC_ADD, 1'b0, 2'd2, 5'd4);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("mul_stall%0d", i), id_ready, 0);
      chk($sformatf("mul_nv%0d", i), tl_valid, 0);
      cyc();
    end
    chk("mul_valid", tl_valid, 1);
    chk("mul_data", tl_data, 42);
    chk("mul_thr", tl_thread, 2);
    chk("mul_flag", tl_flags.mul, 1);
    chk("mul_dst", tl_dst, 9);
    chk("mul_ready4", id_ready, 1);
    cyc();
    chk("b2b_valid", tl_valid, 1);
    chk("b2b_data", tl_data, 3);

    // Back-pressure on a valid result
    tl_ready = 1'b0;
    drive(32'h88, 10, 1, 20, MUX_A_REGFILE, MUX_B_IMM, FUNC_ADD, 1'b0, 2'd0, 5'd5);
    chk("hold_ready0", id_ready, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk($sformatf("hold_data%0d", i), tl_data, 3);
      chk($sformatf("hold_valid%0d", i), tl_valid, 1);
      chk($sformatf("hold_ready%0d", i), id_ready, 0);
    end
    tl_ready = 1'b1;
    #1;
    chk("release_ready", id_ready, 1);
    cyc();
    chk("release_data", tl_data, 30);
    chk("release_valid", tl_valid, 1);
    id_valid = 1'b0;
    cyc();
    chk("release_drain", tl_valid, 0);

    // Flush two cycles into a multiply
    drive(32'h90, 6, 7, 0, MUX_A_REGFILE, MUX_B_REGFILE, FUNC_ADD, 1'b1, 2'd3, 5'd7);
    chk("fl_ready0", id_ready, 1);
    cyc();
    id_valid = 1'b0;
    cyc();
    flush = 1'b1;
    #1;
    chk("fl_ready_during", id_ready, 0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fl_valid", tl_valid, 0);
    chk("fl_ready_after", id_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("fl_nv%0d", i), tl_valid, 0);
      chk($sformatf("fl_data%0d", i), tl_data, 30);
    end

    // BEQ target computation and equality
    drive(32'h100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8, MUX_A_PC, MUX_B_IMM, FUNC_ADD, 1'b0,
          2'd1, 5'd0);
    id_flags.branch = 1'b1;
    #1;
    cyc();
    chk("beq_data", tl_data, 32'h108);
    chk("beq_iseq", tl_isequal, 1);
    chk("beq_branch", tl_flags.branch, 1);
    tl_ready = 1'b0;
    id_valid = 1'b0;
    cyc();
    chk("beq_hold", tl_valid, 1);

    // Reset while a result is held
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst2_valid", tl_valid, 0);
    chk("rst2_data", tl_data, 0);
    chk("rst2_pc", tl_pc, 0);
    chk("rst2_iseq", tl_isequal, 0);
    chk("rst2_ready", id_ready, 1);

    // Reset in the middle of a multiply: no product may surface
    tl_ready = 1'b1;
    drive(32'h200, 6, 7, 0, MUX_A_REGFILE, MUX_B_REGFILE, FUNC_ADD, 1'b1, 2'd2, 5'd1);
    cyc();
    id_valid = 1'b0;
    chk("rmul_stall", id_ready, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rmul_ready", id_ready, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("rmul_nv%0d", i), tl_valid, 0);
      chk($sformatf("rmul_data%0d", i), tl_data, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
